// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and defaults for the cache-line <-> burst-bus adaptor.
// Optional perf counters are enabled with CACHELINE_ADAPTOR_PERF_EN.
package cacheline_adaptor_pkg;

    localparam int BEATS_DEF  = 4;
    localparam int BEAT_W_DEF = 64;
    localparam int LINE_W_DEF = BEATS_DEF * BEAT_W_DEF;

    localparam logic [31:0] LINE_MASK = 32'(LINE_W_DEF / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~LINE_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache pmem port plus 64-bit burst bus, as seen by the adaptor (slave)
// and by the cache/memory environment (master).
interface cacheline_adaptor_if
    import cacheline_adaptor_pkg::*;
#(
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);

    logic [31:0]       address_i;
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic [31:0]       address_o;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport slave (
        input  address_i, line_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, address_o, burst_o, read_o, write_o
    );

    modport master (
        output address_i, line_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, burst_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_adaptor.sv
// Serializes line write-backs into bursts and gathers read bursts into lines.
// Define CACHELINE_ADAPTOR_PERF_EN for rd_lines_o / wr_lines_o counters.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int BEATS  = BEATS_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef CACHELINE_ADAPTOR_PERF_EN
    output logic [31:0] rd_lines_o,
    output logic [31:0] wr_lines_o,
`endif
    cacheline_adaptor_if.slave bus
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    if (LINE_W != BEATS * BEAT_W) begin : g_bad_geom
        $error("LINE_W must equal BEATS*BEAT_W");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;
    logic [31:0]       addr_q, addr_d;
    logic [BEAT_W-1:0] burst_q, burst_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wline_d = wline_q;
        rline_d = rline_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        resp_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.write_i) begin
                    state_d = WRITE;
                    wline_d = bus.line_i;
                    addr_d  = line_align(bus.address_i);
                    burst_d = bus.line_i[0 +: BEAT_W];
                    wr_d    = 1'b1;
                end else if (bus.read_i) begin
                    state_d = READ;
                    addr_d  = line_align(bus.address_i);
                    rd_d    = 1'b1;
                end
            end
            READ: begin
                rd_d = 1'b1;
                if (bus.resp_i) begin
                    rline_d[cnt_q*BEAT_W +: BEAT_W] = bus.burst_i;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                wr_d = 1'b1;
                if (bus.resp_i) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        wr_d    = 1'b0;
                        resp_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        burst_d = wline_q[cnt_d*BEAT_W +: BEAT_W];
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
        end
    end

    assign bus.line_o    = rline_q;
    assign bus.resp_o    = resp_q;
    assign bus.address_o = addr_q;
    assign bus.burst_o   = burst_q;
    assign bus.read_o    = rd_q;
    assign bus.write_o   = wr_q;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_d == DONE) begin
            if (state_q == READ) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (state_q == WRITE) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign rd_lines_o = rd_cnt_q;
    assign wr_lines_o = wr_cnt_q;
`endif

`ifndef SYNTHESIS
    // Cache must never raise both requests; memory must not strobe when idle.
    a_req_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.read_i && bus.write_i));
    a_resp_ctx: assert property (@(posedge clk) disable iff (!rst)
        bus.resp_i |-> (state_q == READ || state_q == WRITE));
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reset, reads, stalled writes,
// back-to-back traffic, mid-burst reset and optional perf counters.
module tb_cacheline_adaptor;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    cacheline_adaptor_if #(.BEAT_W(64), .LINE_W(256)) bus ();

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] rd_lines;
    logic [31:0] wr_lines;
`endif

    cacheline_adaptor #(
        .BEATS (4),
        .BEAT_W(64),
        .LINE_W(256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CACHELINE_ADAPTOR_PERF_EN
        .rd_lines_o(rd_lines),
        .wr_lines_o(wr_lines),
`endif
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_line(input logic [31:0] a,
                           input logic [255:0] data,
                           input int gap);
        logic [31:0] ea;
        ea = {a[31:5], 5'b0};
        chk("rd_pre_read_o", bus.read_o, 1'b0);
        chk("rd_pre_write_o", bus.write_o, 1'b0);
        bus.read_i    = 1'b1;
        bus.address_i = a;
        tick();
        chk("rd_addr", bus.address_o, ea);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                chk("rd_stall_read_o", bus.read_o, 1'b1);
                chk("rd_stall_resp_o", bus.resp_o, 1'b0);
                tick();
            end
            chk("rd_beat_read_o", bus.read_o, 1'b1);
            chk("rd_beat_resp_o", bus.resp_o, 1'b0);
            chk("rd_beat_addr", bus.address_o, ea);
            bus.resp_i  = 1'b1;
            bus.burst_i = data[k*64 +: 64];
            tick();
            bus.resp_i = 1'b0;
        end
        bus.read_i = 1'b0;
        chk("rd_done_resp_o", bus.resp_o, 1'b1);
        chk("rd_done_read_o", bus.read_o, 1'b0);
        chk("rd_done_line", bus.line_o, data);
        tick();
        chk("rd_after_resp_o", bus.resp_o, 1'b0);
        chk("rd_after_line", bus.line_o, data);
    endtask

    task automatic wr_line(input logic [31:0] a,
                           input logic [255:0] line,
                           input int gap);
        logic [31:0] ea;
        ea = {a[31:5], 5'b0};
        chk("wr_pre_write_o", bus.write_o, 1'b0);
        chk("wr_pre_read_o", bus.read_o, 1'b0);
        bus.write_i   = 1'b1;
        bus.address_i = a;
        bus.line_i    = line;
        tick();
        chk("wr_addr", bus.address_o, ea);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                chk("wr_stall_write_o", bus.write_o, 1'b1);
                chk("wr_stall_burst", bus.burst_o, line[k*64 +: 64]);
                chk("wr_stall_resp_o", bus.resp_o, 1'b0);
                tick();
            end
            chk("wr_beat_write_o", bus.write_o, 1'b1);
            chk("wr_beat_burst", bus.burst_o, line[k*64 +: 64]);
            bus.resp_i = 1'b1;
            tick();
            bus.resp_i = 1'b0;
        end
        bus.write_i = 1'b0;
        chk("wr_done_resp_o", bus.resp_o, 1'b1);
        chk("wr_done_write_o", bus.write_o, 1'b0);
        tick();
        chk("wr_after_resp_o", bus.resp_o, 1'b0);
    endtask

    logic [255:0] rl_a;
    logic [255:0] rl_b;
    logic [255:0] rl_c;
    logic [255:0] wl_a;
    logic [255:0] wl_b;

    initial begin
        rl_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rl_b = {64'h0F0E_0D0C_0B0A_0908, 64'h0706_0504_0302_0100,
                64'hA5A5_5A5A_A5A5_5A5A, 64'h8000_0000_0000_0001};
        rl_c = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000};
        wl_a = {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
                64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        wl_b = {64'h1357_9BDF_2468_ACE0, 64'h0000_0000_FFFF_FFFF,
                64'h7FFF_FFFF_FFFF_FFFE, 64'hBEEF_0000_1111_2222};

        rst           = 1'b0;
        bus.address_i = '0;
        bus.line_i    = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;

        // reset: stray resp_i strobes while held in reset
        tick();
        bus.resp_i = 1'b1;
        tick();
        tick();
        bus.resp_i = 1'b0;
        chk("rst_resp_o", bus.resp_o, 1'b0);
        chk("rst_read_o", bus.read_o, 1'b0);
        chk("rst_write_o", bus.write_o, 1'b0);
        chk("rst_line_o", bus.line_o, '0);
        chk("rst_burst_o", bus.burst_o, '0);
        chk("rst_address_o", bus.address_o, '0);
        rst = 1'b1;
        tick();
        tick();
        chk("rel_resp_o", bus.resp_o, 1'b0);
        chk("rel_read_o", bus.read_o, 1'b0);
        chk("rel_write_o", bus.write_o, 1'b0);

        // zero-wait read
        rd_line(32'h1234_5678, rl_a, 0);

        // stalled write, two idle cycles before each accept
        wr_line(32'hABCD_EF1F, wl_a, 2);

        // write-back immediately followed by allocate
        wr_line(32'h0000_1040, wl_b, 0);
        rd_line(32'h0000_2000, rl_b, 1);
        chk("b2b_line_hold", bus.line_o, rl_b);

        // reset after two read beats
        bus.read_i    = 1'b1;
        bus.address_i = 32'h8000_0020;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rl_a[k*64 +: 64];
            tick();
        end
        bus.resp_i = 1'b0;
        chk("mid_read_o_pre", bus.read_o, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_read_o", bus.read_o, 1'b0);
        chk("mid_resp_o", bus.resp_o, 1'b0);
        chk("mid_line_o", bus.line_o, '0);
        chk("mid_address_o", bus.address_o, '0);
        bus.read_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_resp_o", bus.resp_o, 1'b0);
        rd_line(32'h8000_003C, rl_c, 0);

`ifdef CACHELINE_ADAPTOR_PERF_EN
        chk("perf_rd_1", rd_lines, 32'd1);
        chk("perf_wr_0", wr_lines, 32'd0);
        rd_line(32'h0000_0100, rl_a, 0);
        wr_line(32'h0000_0200, wl_a, 1);
        rd_line(32'h0000_0300, rl_b, 0);
        wr_line(32'h0000_0400, wl_b, 0);
        chk("perf_rd_3", rd_lines, 32'd3);
        chk("perf_wr_2", wr_lines, 32'd2);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Responder on the cache's physical-memory port (pmem_read / pmem_write / pmem_resp, 256-bit line) and initiator on the 64-bit burst memory bus.
- Serializes a dirty-line write-back into BEATS beats and gathers BEATS read beats into one line for write-allocate.
- Sits between each cache instance (or the cache arbiter) and main memory.

Parameters:
- BEATS, 4, beats per cache line
- BEAT_W, 64, burst bus data width in bits
- LINE_W, 256, cache line width; must equal BEATS*BEAT_W (elaboration assertion)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- address_i  in  32  cache line address from cache; bits [4:0] ignored
- line_i  in  LINE_W  write-back line from cache
- line_o  out  LINE_W  assembled read line to cache
- read_i  in  1  cache line read request (pmem_read)
- write_i  in  1  cache line write request (pmem_write)
- resp_o  out  1  line transfer complete (pmem_resp)
- address_o  out  32  burst address to memory; {address_i[31:5], 5'b0}
- burst_i  in  BEAT_W  read beat from memory
- burst_o  out  BEAT_W  write beat to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat accept/valid strobe

Behaviour:
- Reset (rst low, asynchronous): state IDLE; resp_o, read_o, write_o = 0; line_o, burst_o, address_o = 0; beat counter = 0. Asserting reset mid-burst aborts the transfer immediately. No partial-line completion follows deassertion.
- States and transitions:
  - IDLE: if write_i, latch line_i and aligned address → WRITE. Else if read_i, latch address → READ. write_i wins if both requests are high (illegal from the cache; a protocol assertion fires).
  - READ: read_o=1. Each cycle with resp_i=1, store burst_i in line_o[cnt*BEAT_W +: BEAT_W] and increment cnt. When the beat with cnt==BEATS-1 is accepted, go to DONE.
  - WRITE: write_o=1; burst_o = latched_line[cnt*BEAT_W +: BEAT_W]. Each resp_i=1 increments cnt. Last beat accepted → DONE.
  - DONE: resp_o=1 for exactly one cycle; cnt cleared; read_i and write_i ignored; go to IDLE.
- All outputs are registered; no combinational path from read_i, write_i, or resp_i to any output.
- address_o, read_o, and write_o are held constant for the whole burst. Memory may insert any number of stall cycles (resp_i=0) between beats.
- Latency with zero-wait memory: request sampled in cycle 0; read_o/write_o high in cycles 1–4; resp_o in cycle 5.
- line_o is valid in the DONE cycle and holds until the next read burst begins. The cache must hold read_i/write_i and line_i until resp_o.
- resp_i outside READ/WRITE is ignored; an assertion flags it.
- cnt is clog2(BEATS) bits wide. It wraps to 0 only via the DONE clear, never by overflow.

Optional Feature:
- Macro CACHELINE_ADAPTOR_PERF_EN.
- When defined: 32-bit outputs rd_lines_o and wr_lines_o each increment once per DONE of the matching type. They wrap modulo 2^32 and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cacheline_adaptor_pkg holds:
  - state enum {IDLE, READ, WRITE, DONE}
  - default BEATS / BEAT_W / LINE_W localparams
  - function aligning an address to a line boundary
- No sub-module; the beat mux/demux is inline indexed part-selects.

Test Plan:
- Reset: hold rst low, then release → all outputs 0, state IDLE; resp_i pulses produce no resp_o.
- Zero-wait read: read_i=1, address_i=0x1234_5678; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles → address_o=0x1234_5660; resp_o in cycle 5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Stalled write: write_i=1, line_i = {D3,D2,D1,D0}; resp_i pulses with 2 idle cycles between beats → burst_o = D0, D1, D2, D3 in order, each held until its resp_i; single resp_o after D3.
- Back-to-back write-back then allocate (cache pattern write_back→write_allocate): write completes, read_i asserted in the cycle after DONE → no overlap, read burst starts one cycle later, both lines correct.
- Reset mid-read after 2 beats: rst low → read_o drops immediately. After release with a new read request, cnt restarts at 0 and the line is fully refilled.
- With CACHELINE_ADAPTOR_PERF_EN defined: 3 reads and 2 writes → rd_lines_o=3, wr_lines_o=2.
